// File: rtl/sync_pkg.sv
// Shared helpers for the multi-channel synchroniser/filter.
`ifndef SYNC_PKG_SV
`define SYNC_PKG_SV

// Elaboration-time parameter guard, expanded as generate items in the top.
`define SYNC_PKG_CHECK_PARAMS(STAGES_P, FILT_P) \
   if ((STAGES_P) < 2) begin : g_chk_stages \
      $error("multi_sync_filter: STAGES must be >= 2"); \
   end \
   if ((FILT_P) < 1) begin : g_chk_filt \
      $error("multi_sync_filter: FILT must be >= 1"); \
   end

package sync_pkg;

   // Ceiling log2, clamped to 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

`endif

// File: rtl/multi_sync_filter_if.sv
// Bus bundle for multi_sync_filter: sample enable, raw inputs and filtered outputs.
interface multi_sync_filter_if #(
   parameter int unsigned N = 8
);
   logic         ena;
   logic [N-1:0] data_in;
   logic [N-1:0] data_out;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic         changed;

   modport master (
      output ena, data_in,
      input  data_out, rise, fall, changed
   );

   modport slave (
      input  ena, data_in,
      output data_out, rise, fall, changed
   );
endinterface

// File: rtl/sync_filter_ch.sv
// One channel's stability filter: counts consecutive differing samples and
// accepts the new level after FILT of them, pulsing rise/fall for one cycle.
module sync_filter_ch
   import sync_pkg::*;
#(
   parameter int unsigned FILT     = 4,
   parameter logic        INIT_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic s,
   output logic data_out,
   output logic rise,
   output logic fall,
   output logic pulse_next
);
   localparam int unsigned CW = clog2(FILT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          dout_q, dout_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Next-state: counter/level update when enabled; pulses default low so they last one cycle.
   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (ena) begin
         if (s == dout_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(FILT - 1)) begin
            dout_d = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         dout_q <= INIT_BIT;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign data_out   = dout_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign pulse_next = rise_d | fall_d;
endmodule

// File: rtl/multi_sync_filter.sv
// N-channel synchroniser: STAGES-deep flop chain per bit, then a per-bit glitch
// filter with edge pulses, plus a registered "any bit changed" flag.
module multi_sync_filter
   import sync_pkg::*;
#(
   parameter int unsigned  N      = 8,
   parameter int unsigned  STAGES = 2,
   parameter int unsigned  FILT   = 4,
   parameter logic [N-1:0] INIT   = '0
) (
   input logic                clk,
   input logic                rst_n,
   multi_sync_filter_if.slave bus
);
   `SYNC_PKG_CHECK_PARAMS(STAGES, FILT)

   logic [STAGES-1:0][N-1:0] chain_q;
   logic [N-1:0]             s;
   logic [N-1:0]             data_out;
   logic [N-1:0]             rise;
   logic [N-1:0]             fall;
   logic [N-1:0]             pulse_next;
   logic                     changed_q;

   // Synchroniser chain; holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= {STAGES{INIT}};
      end else if (bus.ena) begin
         chain_q[0] <= bus.data_in;
         for (int i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign s = chain_q[STAGES-1];

   for (genvar g = 0; g < N; g++) begin : g_ch
      sync_filter_ch #(
         .FILT     (FILT),
         .INIT_BIT (INIT[g])
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .ena        (bus.ena),
         .s          (s[g]),
         .data_out   (data_out[g]),
         .rise       (rise[g]),
         .fall       (fall[g]),
         .pulse_next (pulse_next[g])
      );
   end

   // Registered from next-state pulses so it lines up with rise/fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) changed_q <= 1'b0;
      else        changed_q <= |pulse_next;
   end

   assign bus.data_out = data_out;
   assign bus.rise     = rise;
   assign bus.fall     = fall;
   assign bus.changed  = changed_q;
endmodule

// File: tb/tb_multi_sync_filter.sv
// Self-checking bench for multi_sync_filter.
module tb_multi_sync_filter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   multi_sync_filter_if #(.N(8))  bus_a5 ();
   multi_sync_filter_if #(.N(8))  bus_def ();
   multi_sync_filter_if #(.N(1))  bus_s1 ();
   multi_sync_filter_if #(.N(8))  bus_s2 ();
   multi_sync_filter_if #(.N(16)) bus_s3 ();

   multi_sync_filter #(.N(8), .STAGES(2), .FILT(4), .INIT(8'hA5)) u_a5 (
      .clk (clk), .rst_n (rst_n), .bus (bus_a5));
   multi_sync_filter #(.N(8)) u_def (
      .clk (clk), .rst_n (rst_n), .bus (bus_def));
   multi_sync_filter #(.N(1), .STAGES(2), .FILT(1)) u_s1 (
      .clk (clk), .rst_n (rst_n), .bus (bus_s1));
   multi_sync_filter #(.N(8), .STAGES(3), .FILT(2)) u_s2 (
      .clk (clk), .rst_n (rst_n), .bus (bus_s2));
   multi_sync_filter #(.N(16), .STAGES(4), .FILT(8)) u_s3 (
      .clk (clk), .rst_n (rst_n), .bus (bus_s3));

   // Reference model state, widest case (16 bits, up to 4 stages, 4-bit counters).
   typedef struct packed {
      logic [3:0][15:0] chain;
      logic [15:0]      dout;
      logic [15:0][3:0] cnt;
      logic [15:0]      rise;
      logic [15:0]      fall;
      logic             changed;
   } model_t;

   typedef struct packed {
      logic [15:0] dout;
      logic [15:0] rise;
      logic [15:0] fall;
      logic        changed;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t q3[$];

   function automatic model_t model_step(model_t m, logic [15:0] din, logic en,
                                         int n, int stages, int filt);
      model_t      r;
      logic [15:0] s;
      r      = m;
      r.rise = '0;
      r.fall = '0;
      if (en) begin
         s = m.chain[stages-1];
         for (int b = 0; b < n; b++) begin
            if (s[b] == m.dout[b]) begin
               r.cnt[b] = '0;
            end else if (int'(m.cnt[b]) == filt - 1) begin
               r.dout[b] = s[b];
               r.cnt[b]  = '0;
               if (s[b]) r.rise[b] = 1'b1;
               else      r.fall[b] = 1'b1;
            end else begin
               r.cnt[b] = m.cnt[b] + 4'd1;
            end
         end
         for (int i = 3; i >= 1; i--) r.chain[i] = m.chain[i-1];
         r.chain[0] = din;
      end
      r.changed = |(r.rise | r.fall);
      return r;
   endfunction

   function automatic exp_t to_exp(model_t m);
      exp_t e;
      e.dout    = m.dout;
      e.rise    = m.rise;
      e.fall    = m.fall;
      e.changed = m.changed;
      return e;
   endfunction

   // Reset pulse spanning two rising edges; returns at the releasing negedge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus_a5.data_in  = 8'hA5;
      bus_a5.ena      = 1'b1;
      bus_def.data_in = 8'h00;
      bus_def.ena     = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_a5.data_out, bus_a5.rise, bus_a5.fall, bus_a5.changed} !== {8'hA5, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_a5: dout=%h rise=%h fall=%h chg=%b, want dout=a5 others 0",
                  bus_a5.data_out, bus_a5.rise, bus_a5.fall, bus_a5.changed);
      end
      checks++;
      if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !== 25'd0) begin
         errors++;
         $display("FAIL reset_def: dout=%h rise=%h fall=%h chg=%b, want all 0",
                  bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({bus_a5.data_out, bus_a5.rise, bus_a5.fall, bus_a5.changed} !== {8'hA5, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_release cyc %0d: dout=%h rise=%h fall=%h chg=%b, want a5/0/0/0",
                     k, bus_a5.data_out, bus_a5.rise, bus_a5.fall, bus_a5.changed);
         end
      end
   endtask

   task automatic test_latency();
      logic [7:0] exp_d, exp_r;
      bus_def.ena     = 1'b1;
      bus_def.data_in = 8'h00;
      do_reset();
      bus_def.data_in = 8'h01;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         exp_d = (k >= 6) ? 8'h01 : 8'h00;
         exp_r = (k == 6) ? 8'h01 : 8'h00;
         checks++;
         if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !==
             {exp_d, exp_r, 8'h00, |exp_r}) begin
            errors++;
            $display("FAIL latency edge %0d: dout=%h rise=%h fall=%h chg=%b, want %h/%h/00/%b",
                     k, bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed,
                     exp_d, exp_r, |exp_r);
         end
      end
   endtask

   task automatic test_glitch();
      int rise_at, fall_at, rise_cnt, fall_cnt;
      bus_def.ena     = 1'b1;
      bus_def.data_in = 8'h00;
      do_reset();
      bus_def.data_in = 8'h08;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !== 25'd0) begin
            errors++;
            $display("FAIL glitch3 edge %0d: dout=%h rise=%h fall=%h chg=%b, want all 0",
                     k, bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed);
         end
         if (k == 3) begin
            @(negedge clk);
            bus_def.data_in = 8'h00;
         end
      end
      rise_at = 0; fall_at = 0; rise_cnt = 0; fall_cnt = 0;
      @(negedge clk);
      bus_def.data_in = 8'h08;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (bus_def.rise != 8'h00) begin
            rise_cnt++;
            if (bus_def.rise == 8'h08) rise_at = k;
         end
         if (bus_def.fall != 8'h00) begin
            fall_cnt++;
            if (bus_def.fall == 8'h08) fall_at = k;
         end
         if (k == 8) begin
            checks++;
            if (bus_def.data_out !== 8'h08) begin
               errors++;
               $display("FAIL glitch4_level: dout=%h, want 08", bus_def.data_out);
            end
         end
         if (k == 4) begin
            @(negedge clk);
            bus_def.data_in = 8'h00;
         end
      end
      checks++;
      if (rise_cnt != 1 || rise_at != 6) begin
         errors++;
         $display("FAIL glitch4_rise: count=%0d edge=%0d, want count=1 edge=6", rise_cnt, rise_at);
      end
      checks++;
      if (fall_cnt != 1 || fall_at != 10) begin
         errors++;
         $display("FAIL glitch4_fall: count=%0d edge=%0d, want count=1 edge=10", fall_cnt, fall_at);
      end
      checks++;
      if (bus_def.data_out !== 8'h00) begin
         errors++;
         $display("FAIL glitch4_final: dout=%h, want 00", bus_def.data_out);
      end
   endtask

   task automatic test_ena_toggle();
      logic [7:0] exp_d, exp_r;
      bus_def.ena     = 1'b1;
      bus_def.data_in = 8'h00;
      do_reset();
      bus_def.data_in = 8'h01;
      bus_def.ena     = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         exp_d = (k >= 11) ? 8'h01 : 8'h00;
         exp_r = (k == 11) ? 8'h01 : 8'h00;
         checks++;
         if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !==
             {exp_d, exp_r, 8'h00, |exp_r}) begin
            errors++;
            $display("FAIL ena_toggle edge %0d: dout=%h rise=%h fall=%h chg=%b, want %h/%h/00/%b",
                     k, bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed,
                     exp_d, exp_r, |exp_r);
         end
         @(negedge clk);
         bus_def.ena = ~bus_def.ena;
      end
      bus_def.ena = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d, exp_r;
      bus_def.ena     = 1'b1;
      bus_def.data_in = 8'h00;
      do_reset();
      bus_def.data_in = 8'hFF;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !== 25'd0) begin
         errors++;
         $display("FAIL reset_mid_async: dout=%h rise=%h fall=%h chg=%b, want all 0",
                  bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         exp_d = (k >= 6) ? 8'hFF : 8'h00;
         exp_r = (k == 6) ? 8'hFF : 8'h00;
         checks++;
         if ({bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed} !==
             {exp_d, exp_r, 8'h00, |exp_r}) begin
            errors++;
            $display("FAIL reset_mid edge %0d: dout=%h rise=%h fall=%h chg=%b, want %h/%h/00/%b",
                     k, bus_def.data_out, bus_def.rise, bus_def.fall, bus_def.changed,
                     exp_d, exp_r, |exp_r);
         end
      end
      // Asynchronous clear of a settled high level, mid-cycle.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_def.data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_async_level: dout=%h, want 00", bus_def.data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      model_t      m1, m2, m3;
      exp_t        e, act;
      logic [15:0] base, din;
      logic        en;
      bus_s1.ena = 1'b0; bus_s2.ena = 1'b0; bus_s3.ena = 1'b0;
      bus_s1.data_in = '0; bus_s2.data_in = '0; bus_s3.data_in = '0;
      do_reset();
      m1 = '0; m2 = '0; m3 = '0;
      base = 16'h0000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 14) == 0) base = 16'($urandom);
         din = base;
         if ($urandom_range(0, 4) == 0) din = din ^ (16'h1 << $urandom_range(0, 15));
         en = ($urandom_range(0, 5) != 0);
         bus_s1.data_in = din[0:0];
         bus_s2.data_in = din[7:0];
         bus_s3.data_in = din;
         bus_s1.ena = en; bus_s2.ena = en; bus_s3.ena = en;
         m1 = model_step(m1, {15'd0, din[0]}, en, 1, 2, 1);
         m2 = model_step(m2, {8'd0, din[7:0]}, en, 8, 3, 2);
         m3 = model_step(m3, din, en, 16, 4, 8);
         q1.push_back(to_exp(m1));
         q2.push_back(to_exp(m2));
         q3.push_back(to_exp(m3));
         @(posedge clk);
         #1;
         // N=1, STAGES=2, FILT=1
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sweep_s1 cyc %0d: scoreboard empty", cyc);
         end else begin
            e   = q1.pop_front();
            act = '{16'(bus_s1.data_out), 16'(bus_s1.rise), 16'(bus_s1.fall), bus_s1.changed};
            if (act !== e) begin
               errors++;
               $display("FAIL sweep_s1 cyc %0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                        act.dout, act.rise, act.fall, act.changed, e.dout, e.rise, e.fall, e.changed);
            end
         end
         // N=8, STAGES=3, FILT=2
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL sweep_s2 cyc %0d: scoreboard empty", cyc);
         end else begin
            e   = q2.pop_front();
            act = '{16'(bus_s2.data_out), 16'(bus_s2.rise), 16'(bus_s2.fall), bus_s2.changed};
            if (act !== e) begin
               errors++;
               $display("FAIL sweep_s2 cyc %0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                        act.dout, act.rise, act.fall, act.changed, e.dout, e.rise, e.fall, e.changed);
            end
         end
         // N=16, STAGES=4, FILT=8
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL sweep_s3 cyc %0d: scoreboard empty", cyc);
         end else begin
            e   = q3.pop_front();
            act = '{bus_s3.data_out, bus_s3.rise, bus_s3.fall, bus_s3.changed};
            if (act !== e) begin
               errors++;
               $display("FAIL sweep_s3 cyc %0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                        act.dout, act.rise, act.fall, act.changed, e.dout, e.rise, e.fall, e.changed);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bus_a5.ena = 1'b0;  bus_a5.data_in = 8'h00;
      bus_def.ena = 1'b0; bus_def.data_in = 8'h00;
      bus_s1.ena = 1'b0;  bus_s1.data_in = '0;
      bus_s2.ena = 1'b0;  bus_s2.data_in = '0;
      bus_s3.ena = 1'b0;  bus_s3.data_in = '0;
      test_reset();
      test_latency();
      test_glitch();
      test_ena_toggle();
      test_reset_mid();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
